// File: rtl/freqcnt_pkg.sv
// rtl/freqcnt_pkg.sv - register map, state type and error codes for the frequency counter sequencer
package freqcnt_pkg;

   localparam logic [5:0] ADDR_SEL   = 6'h21;
   localparam logic [5:0] ADDR_SMP   = 6'h22;
   localparam logic [5:0] ADDR_START = 6'h2F;
   localparam logic [5:0] ADDR_AVG   = 6'h11;

   localparam int         NUM_WORDS = 9;
   localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - 1);

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_ZERO    = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CFG_SEL,
      S_CFG_SMP,
      S_CFG_GO,
      S_WAIT_IRQ,
      S_RD_REQ,
      S_RD_CAP,
      S_RD_OUT
   } state_t;

   // Word 0 is the average, words 1..8 the buffer; they sit contiguously from AVG.
   function automatic logic [5:0] rd_addr(input logic [3:0] k);
      return ADDR_AVG + {2'b00, k};
   endfunction

endpackage

// File: rtl/freqcnt_sequencer_if.sv
// rtl/freqcnt_sequencer_if.sv - command, counter bus and result stream bundle of the sequencer
interface freqcnt_sequencer_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_select;
   logic [9:0]  cmd_samples;

   logic [5:0]  fc_addr;
   logic [15:0] fc_wdata;
   logic        fc_cfg_stb;
   logic        fc_rsp_stb;
   logic [15:0] fc_rdata;
   logic        fc_irq;

   logic        res_valid;
   logic        res_ready;
   logic [3:0]  res_index;
   logic [9:0]  res_data;
   logic        res_last;

   logic        busy;
   logic        err;
   logic [1:0]  err_code;

   modport master (
      input  cmd_valid, cmd_select, cmd_samples, fc_rdata, fc_irq, res_ready,
      output cmd_ready, fc_addr, fc_wdata, fc_cfg_stb, fc_rsp_stb,
             res_valid, res_index, res_data, res_last, busy, err, err_code
   );

   modport slave (
      output cmd_valid, cmd_select, cmd_samples, fc_rdata, fc_irq, res_ready,
      input  cmd_ready, fc_addr, fc_wdata, fc_cfg_stb, fc_rsp_stb,
             res_valid, res_index, res_data, res_last, busy, err, err_code
   );

endinterface

// File: rtl/freqcnt_timeout.sv
// rtl/freqcnt_timeout.sv - loadable up-counter flagging expiry at TIMEOUT_CYCLES-1
module freqcnt_timeout #(
   parameter  int TIMEOUT_CYCLES = 1_000_000,
   localparam int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic          Clock,
   input  logic          nReset,
   input  logic          clear_i,
   input  logic          enable_i,
   input  logic          load_i,
   input  logic [TW-1:0] load_value_i,
   output logic          expired_o
);

   localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] count_q;
   logic [TW-1:0] count_d;

   // Counting stops at the limit so the flag stays up until cleared.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = load_value_i;
      end else if (enable_i && !expired_o) begin
         count_d = count_q + TW'(1);
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/freqcnt_sequencer.sv
// rtl/freqcnt_sequencer.sv - runs configure/start/wait/readback on the frequency counter bus
// and streams the nine result words out.
module freqcnt_sequencer
   import freqcnt_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input logic                 Clock,
   input logic                 nReset,
   freqcnt_sequencer_if.master bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t      state_q;
   logic [9:0]  smp_q;
   logic [3:0]  k_q;
   logic [3:0]  k_d;
   logic        cmd_ready_q;
   logic [5:0]  fc_addr_q;
   logic [15:0] fc_wdata_q;
   logic        fc_cfg_stb_q;
   logic        fc_rsp_stb_q;
   logic        res_valid_q;
   logic [3:0]  res_index_q;
   logic [9:0]  res_data_q;
   logic        res_last_q;
   logic        busy_q;
   logic        err_q;
   logic [1:0]  err_code_q;
   logic        tmo_expired;
   logic [5:0]  unused_rdata;

   assign k_d          = k_q + 4'd1;
   assign unused_rdata = bus.fc_rdata[15:10];

   // Held clear outside WAIT_IRQ so every wait starts counting from zero.
   freqcnt_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .Clock       (Clock),
      .nReset      (nReset),
      .clear_i     (state_q != S_WAIT_IRQ),
      .enable_i    (state_q == S_WAIT_IRQ),
      .load_i      (1'b0),
      .load_value_i({TW{1'b0}}),
      .expired_o   (tmo_expired)
   );

   // All bus outputs are registered with the state, so each strobe lines up with its state.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q      <= S_IDLE;
         smp_q        <= '0;
         k_q          <= '0;
         cmd_ready_q  <= 1'b1;
         fc_addr_q    <= '0;
         fc_wdata_q   <= '0;
         fc_cfg_stb_q <= 1'b0;
         fc_rsp_stb_q <= 1'b0;
         res_valid_q  <= 1'b0;
         res_index_q  <= '0;
         res_data_q   <= '0;
         res_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= ERR_NONE;
      end else begin
         fc_cfg_stb_q <= 1'b0;
         fc_rsp_stb_q <= 1'b0;
         fc_addr_q    <= '0;
         fc_wdata_q   <= '0;
         err_q        <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (bus.cmd_valid && cmd_ready_q) begin
                  smp_q      <= bus.cmd_samples;
                  k_q        <= '0;
                  err_code_q <= ERR_NONE;
                  if (bus.cmd_samples == '0) begin
                     err_q      <= 1'b1;
                     err_code_q <= ERR_ZERO;
                  end else begin
                     state_q      <= S_CFG_SEL;
                     cmd_ready_q  <= 1'b0;
                     busy_q       <= 1'b1;
                     fc_cfg_stb_q <= 1'b1;
                     fc_addr_q    <= ADDR_SEL;
                     fc_wdata_q   <= {11'b0, bus.cmd_select};
                  end
               end
            end

            S_CFG_SEL: begin
               state_q      <= S_CFG_SMP;
               fc_cfg_stb_q <= 1'b1;
               fc_addr_q    <= ADDR_SMP;
               fc_wdata_q   <= {6'b0, smp_q};
            end

            S_CFG_SMP: begin
               state_q      <= S_CFG_GO;
               fc_cfg_stb_q <= 1'b1;
               fc_addr_q    <= ADDR_START;
            end

            S_CFG_GO: begin
               state_q <= S_WAIT_IRQ;
            end

            S_WAIT_IRQ: begin
               if (bus.fc_irq) begin
                  state_q      <= S_RD_REQ;
                  k_q          <= '0;
                  fc_rsp_stb_q <= 1'b1;
                  fc_addr_q    <= rd_addr(4'd0);
               end else if (tmo_expired) begin
                  state_q     <= S_IDLE;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  err_q       <= 1'b1;
                  err_code_q  <= ERR_TIMEOUT;
               end
            end

            S_RD_REQ: begin
               state_q <= S_RD_CAP;
            end

            S_RD_CAP: begin
               state_q     <= S_RD_OUT;
               res_valid_q <= 1'b1;
               res_data_q  <= bus.fc_rdata[9:0];
               res_index_q <= k_q;
               res_last_q  <= (k_q == LAST_WORD);
            end

            S_RD_OUT: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  if (k_q == LAST_WORD) begin
                     state_q     <= S_IDLE;
                     cmd_ready_q <= 1'b1;
                     busy_q      <= 1'b0;
                  end else begin
                     state_q      <= S_RD_REQ;
                     k_q          <= k_d;
                     fc_rsp_stb_q <= 1'b1;
                     fc_addr_q    <= rd_addr(k_d);
                  end
               end
            end

            default: begin
               state_q     <= S_IDLE;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
               res_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.fc_addr    = fc_addr_q;
   assign bus.fc_wdata   = fc_wdata_q;
   assign bus.fc_cfg_stb = fc_cfg_stb_q;
   assign bus.fc_rsp_stb = fc_rsp_stb_q;
   assign bus.res_valid  = res_valid_q;
   assign bus.res_index  = res_index_q;
   assign bus.res_data   = res_data_q;
   assign bus.res_last   = res_last_q;
   assign bus.busy       = busy_q;
   assign bus.err        = err_q;
   assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_freqcnt_sequencer.sv
// tb/tb_freqcnt_sequencer.sv - randomized self-checking bench for freqcnt_sequencer
module tb_freqcnt_sequencer;

   localparam int          TMO        = 64;
   localparam logic [63:0] RESET_OUTS = 64'h1 << 44;

   logic clk    = 1'b0;
   logic nreset = 1'b0;
   int   cyc    = 0;

   int vectors     = 0;
   int miscompares = 0;

   freqcnt_sequencer_if bus();

   freqcnt_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
      .Clock (clk),
      .nReset(nreset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Counter responder: data for the strobed word appears the next cycle, junk otherwise.
   logic [15:0] resp_mem [9];
   int          ri;
   always @(posedge clk) begin
      ri = int'(bus.fc_addr) - 17;
      if (bus.fc_rsp_stb && ri >= 0 && ri < 9) bus.fc_rdata <= resp_mem[ri];
      else bus.fc_rdata <= 16'($urandom);
   end

   // Bus/stream monitor, sampled on the falling edge.
   logic [21:0] cfg_q[$];
   int          cfg_cyc[$];
   logic [5:0]  rsp_q[$];
   int          rsp_cyc[$];
   logic [14:0] res_q[$];
   int          xfer_cyc[$];
   int          vrise[$];
   int          err_cyc[$];
   int          acc_q[$];
   int          both_stb = 0, idle_bus = 0, busy_bad = 0, stall_bad = 0, stall_cycles = 0;
   logic        pv = 1'b0, stalled = 1'b0;
   logic [14:0] hold = '0;

   always @(negedge clk) begin
      if (!nreset) begin
         pv      = 1'b0;
         stalled = 1'b0;
      end else begin
         if (bus.fc_cfg_stb && bus.fc_rsp_stb) both_stb++;
         if (!bus.fc_cfg_stb && !bus.fc_rsp_stb && (bus.fc_addr != 0 || bus.fc_wdata != 0)) idle_bus++;
         if (bus.busy == bus.cmd_ready) busy_bad++;
         if (bus.fc_cfg_stb) begin
            cfg_q.push_back({bus.fc_addr, bus.fc_wdata});
            cfg_cyc.push_back(cyc);
         end
         if (bus.fc_rsp_stb) begin
            rsp_q.push_back(bus.fc_addr);
            rsp_cyc.push_back(cyc);
         end
         if (bus.res_valid && !pv) vrise.push_back(cyc);
         if (stalled) begin
            stall_cycles++;
            if (!bus.res_valid || {bus.res_last, bus.res_index, bus.res_data} != hold) stall_bad++;
         end
         stalled = bus.res_valid && !bus.res_ready;
         hold    = {bus.res_last, bus.res_index, bus.res_data};
         pv      = bus.res_valid;
         if (bus.res_valid && bus.res_ready) begin
            res_q.push_back({bus.res_last, bus.res_index, bus.res_data});
            xfer_cyc.push_back(cyc);
         end
         if (bus.err) err_cyc.push_back(cyc);
         if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({bus.cmd_ready, bus.fc_addr, bus.fc_wdata, bus.fc_cfg_stb, bus.fc_rsp_stb,
                  bus.res_valid, bus.res_index, bus.res_data, bus.res_last,
                  bus.busy, bus.err, bus.err_code});
   endfunction

   // One command end to end; irq_dly < 0 means the counter never interrupts.
   task automatic run_cmd(input logic [4:0] sel, input logic [9:0] smp, input int irq_dly,
                          input int stall_word, input bit stale, input bit rnd_ready,
                          input int abort_word);
      logic [15:0] w [9];
      logic [21:0] ec [3];
      int cb, rb, xb, vb, eb, ab, sb, go_cyc, irq_cyc, n, stall_n, cs, rs;
      bit done, irq_on, aborted;

      for (int k = 0; k < 9; k++) begin
         w[k]        = 16'($urandom);
         resp_mem[k] = w[k];
      end
      ec[0] = {6'h21, 11'b0, sel};
      ec[1] = {6'h22, 6'b0, smp};
      ec[2] = {6'h2F, 16'h0000};
      cb = cfg_q.size(); rb = rsp_q.size(); xb = res_q.size(); vb = vrise.size();
      eb = err_cyc.size(); ab = acc_q.size(); sb = stall_cycles;
      go_cyc = -1; irq_cyc = -1; n = 0; stall_n = 0;
      done = 0; irq_on = 0; aborted = 0;

      check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_select  = sel;
      bus.cmd_samples = smp;
      bus.cmd_valid   = 1'b1;
      bus.res_ready   = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_select  = 5'($urandom);
      bus.cmd_samples = 10'($urandom);

      while (!done && n < 400) begin
         if (bus.fc_cfg_stb && bus.fc_addr == 6'h2F) go_cyc = cyc;
         if (irq_dly >= 0 && go_cyc >= 0 && irq_cyc < 0 && cyc == go_cyc + irq_dly) begin
            irq_cyc = cyc;
            irq_on  = 1'b1;
         end
         if (irq_on && bus.fc_rsp_stb) irq_on = 1'b0;
         bus.fc_irq = irq_on || (stale && bus.fc_cfg_stb && bus.fc_addr == 6'h22);
         if (stall_word >= 0 && bus.res_valid && int'(bus.res_index) == stall_word && stall_n < 10) begin
            bus.res_ready = 1'b0;
            stall_n++;
         end else begin
            bus.res_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         if (abort_word >= 0 && bus.res_valid && int'(bus.res_index) == abort_word) begin
            nreset = 1'b0;
            #1;
            check("reset_mid_outs", outs(), RESET_OUTS);
            aborted = 1'b1;
            done    = 1'b1;
         end else if (res_q.size() > xb && res_q[res_q.size()-1][14]) begin
            done = 1'b1;
         end else if (err_cyc.size() > eb) begin
            done = 1'b1;
         end
         if (!done) begin
            @(posedge clk); #1;
            n++;
         end
      end
      bus.fc_irq    = 1'b0;
      bus.res_ready = 1'b1;
      check("cycle_budget", 64'(n < 400), 64'd1);

      if (aborted) begin
         cs = cfg_q.size();
         rs = rsp_q.size();
         repeat (2) @(posedge clk);
         #1;
         nreset = 1'b1;
         repeat (3) @(posedge clk);
         #1;
         check("post_reset_outs", outs(), RESET_OUTS);
         check("post_reset_strobes", 64'((cfg_q.size() - cs) + (rsp_q.size() - rs)), 64'd0);
      end else begin
         check("idle_after", 64'({bus.cmd_ready, bus.busy}), 64'b10);
         repeat (3) @(posedge clk);
         #1;
         check("accepted", 64'(acc_q.size() - ab), 64'd1);
         if (smp == 0) begin
            check("zero_cfg_cnt", 64'(cfg_q.size() - cb), 64'd0);
            check("zero_rsp_cnt", 64'(rsp_q.size() - rb), 64'd0);
            check("zero_err_cnt", 64'(err_cyc.size() - eb), 64'd1);
            check("zero_err_code", 64'(bus.err_code), 64'b10);
            check("zero_cmd_ready", 64'(bus.cmd_ready), 64'd1);
            if (err_cyc.size() > eb && acc_q.size() > ab)
               check("zero_err_cyc", 64'(err_cyc[eb]), 64'(acc_q[ab] + 1));
         end else begin
            check("cfg_cnt", 64'(cfg_q.size() - cb), 64'd3);
            if (cfg_q.size() - cb == 3 && acc_q.size() > ab) begin
               for (int i = 0; i < 3; i++) begin
                  check("cfg_word", 64'(cfg_q[cb+i]), 64'(ec[i]));
                  check("cfg_cyc", 64'(cfg_cyc[cb+i]), 64'(acc_q[ab] + 1 + i));
               end
            end
            if (irq_dly < 0) begin
               check("tmo_rsp_cnt", 64'(rsp_q.size() - rb), 64'd0);
               check("tmo_err_cnt", 64'(err_cyc.size() - eb), 64'd1);
               check("tmo_err_code", 64'(bus.err_code), 64'b01);
               check("tmo_cmd_ready", 64'(bus.cmd_ready), 64'd1);
               if (err_cyc.size() > eb)
                  check("tmo_err_cyc", 64'(err_cyc[eb]), 64'(go_cyc + 1 + TMO));
            end else begin
               check("ok_err_cnt", 64'(err_cyc.size() - eb), 64'd0);
               check("ok_err_code", 64'(bus.err_code), 64'b00);
               check("rsp_cnt", 64'(rsp_q.size() - rb), 64'd9);
               check("res_cnt", 64'(res_q.size() - xb), 64'd9);
               if (vrise.size() > vb)
                  check("irq_to_valid", 64'(vrise[vb]), 64'(irq_cyc + 3));
               if (rsp_q.size() - rb == 9 && res_q.size() - xb == 9) begin
                  check("irq_to_rsp", 64'(rsp_cyc[rb]), 64'(irq_cyc + 1));
                  for (int k = 0; k < 9; k++) begin
                     check("rsp_addr", 64'(rsp_q[rb+k]), 64'(6'h11 + k));
                     check("res_word", 64'(res_q[xb+k]), 64'({k == 8, 4'(k), w[k][9:0]}));
                     if (k > 0) check("rsp_after_xfer", 64'(rsp_cyc[rb+k]), 64'(xfer_cyc[xb+k-1] + 1));
                  end
               end
               if (stall_word >= 0) check("stall_seen", 64'((stall_cycles - sb) >= 10), 64'd1);
            end
         end
      end
   endtask

   initial begin
      bus.cmd_valid   = 1'b0;
      bus.cmd_select  = '0;
      bus.cmd_samples = '0;
      bus.fc_irq      = 1'b0;
      bus.res_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", outs(), RESET_OUTS);
      nreset = 1'b1;
      @(posedge clk); #1;

      run_cmd(5'd5, 10'd100, 50, -1, 1'b0, 1'b0, -1);
      run_cmd(5'($urandom), 10'($urandom_range(1, 1023)), $urandom_range(1, 60), 3, 1'b0, 1'b0, -1);
      run_cmd(5'($urandom), 10'($urandom_range(1, 1023)), -1, -1, 1'b0, 1'b0, -1);
      run_cmd(5'($urandom), 10'd0, 10, -1, 1'b0, 1'b0, -1);
      run_cmd(5'($urandom), 10'($urandom_range(1, 1023)), TMO, -1, 1'b0, 1'b0, -1);
      run_cmd(5'($urandom), 10'($urandom_range(1, 1023)), 30, -1, 1'b1, 1'b0, -1);
      run_cmd(5'($urandom), 10'($urandom_range(1, 1023)), 40, -1, 1'b0, 1'b0, 4);
      run_cmd(5'($urandom), 10'($urandom_range(1, 1023)), 20, -1, 1'b0, 1'b0, -1);
      for (int i = 0; i < 8; i++) begin
         run_cmd(5'($urandom), 10'($urandom_range(1, 1023)), $urandom_range(1, 60), -1,
                 1'($urandom_range(0, 1)), 1'b1, -1);
      end

      check("both_strobes", 64'(both_stb), 64'd0);
      check("idle_bus_nonzero", 64'(idle_bus), 64'd0);
      check("busy_vs_ready", 64'(busy_bad), 64'd0);
      check("stall_stability", 64'(stall_bad), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
